key_uart_streamer: RTL and testbench

- Parametrised successor to the fixed 32-byte key-to-UART path.
- Snapshots a wide key word on a start request and serialises it byte by byte over a built-in UART transmitter.
- Optional header byte, optional XOR checksum byte, optional even parity, configurable stop bits and byte order.
- Gated by an enable (PIN-verified) input; sits between the key source (AES output) and the board TX pin.

---
 rtl/key_uart_streamer.sv | 180 ++++++++++++++++++
 tb/tb_key_uart_streamer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/key_uart_streamer.sv
// Snapshots a wide key word on request and streams it over a built-in UART transmitter,
// framed with an optional header byte, optional XOR checksum and optional even parity.
module key_uart_streamer #(
  parameter int          CLKS_PER_BIT = 87,
  parameter int          NUM_BYTES    = 32,
  parameter int          MSB_FIRST    = 0,
  parameter int          HEADER_EN    = 1,
  parameter logic [7:0]  HEADER_BYTE  = 8'hA5,
  parameter int          CHK_EN       = 1,
  parameter int          PARITY_EN    = 0,
  parameter int          STOP_BITS    = 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  enable_i,
  input  logic                                  start_i,
  input  logic [NUM_BYTES*8-1:0]                key_i,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic                                  abort_o,
  output logic [$clog2(NUM_BYTES+2)-1:0]        byte_idx_o,
  output logic                                  tx_o
);

  localparam int IW = $clog2(NUM_BYTES + 2);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int NF = HEADER_EN + NUM_BYTES + CHK_EN;
  localparam logic [IW-1:0] LAST_IDX  = IW'(NF - 1);
  localparam logic [CW-1:0] CNT_END   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE   = CW'(CLKS_PER_BIT - 2);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP, NEXT} state_t;

  state_t                 state;
  logic [NUM_BYTES*8-1:0] shadow;
  logic [7:0]             cur;
  logic [7:0]             chk;
  logic [CW-1:0]          cnt;
  logic [2:0]             bit_cnt;
  logic                   stop_cnt;
  logic                   abort_flag;

  logic [IW-1:0]          key_pos;
  logic [7:0]             key_byte;
  logic [7:0]             frame_byte;
  logic                   is_key;
  logic                   quit;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

  always_comb begin
    key_pos = byte_idx_o - IW'(HEADER_EN);
    if (MSB_FIRST != 0) key_pos = IW'(NUM_BYTES - 1) - key_pos;
    key_byte   = 8'(shadow >> {key_pos, 3'b000});
    frame_byte = key_byte;
    is_key     = 1'b1;
    if (HEADER_EN != 0 && byte_idx_o == '0) begin
      frame_byte = HEADER_BYTE;
      is_key     = 1'b0;
    end else if (CHK_EN != 0 && byte_idx_o == LAST_IDX) begin
      frame_byte = chk;
      is_key     = 1'b0;
    end
    // an enable drop on the very edge that closes a frame still counts as an abort
    quit = abort_flag | ~enable_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      tx_o       <= 1'b1;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      abort_o    <= 1'b0;
      byte_idx_o <= '0;
      chk        <= '0;
      cnt        <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      abort_flag <= 1'b0;
    end else begin
      done_o  <= 1'b0;
      abort_o <= 1'b0;
      if (busy_o && !enable_i) abort_flag <= 1'b1;
      case (state)
        IDLE: begin
          if (start_i && enable_i) begin
            shadow     <= key_i;
            state      <= LOAD;
            busy_o     <= 1'b1;
            tx_o       <= 1'b0;
            byte_idx_o <= '0;
            chk        <= '0;
            cnt        <= '0;
            abort_flag <= 1'b0;
          end
        end
        // LOAD is the first cycle of every start bit: pick the byte for this frame
        LOAD: begin
          cur <= frame_byte;
          if (is_key) chk <= chk ^ frame_byte;
          cnt   <= cnt + 1'b1;
          state <= START;
        end
        START: begin
          if (cnt == CNT_END) begin
            cnt     <= '0;
            bit_cnt <= '0;
            tx_o    <= cur[0];
            state   <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_END) begin
            cnt <= '0;
            if (bit_cnt == 3'd7) begin
              if (PARITY_EN != 0) begin
                tx_o  <= even_parity(cur);
                state <= PARITY;
              end else begin
                tx_o     <= 1'b1;
                stop_cnt <= 1'b0;
                state    <= STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx_o    <= cur[bit_cnt + 3'd1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (cnt == CNT_END) begin
            cnt      <= '0;
            tx_o     <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // the final cycle of the last stop bit is spent in NEXT, where the frame sequence decides
        STOP: begin
          if (stop_cnt == STOP_LAST && cnt == CNT_PRE) begin
            cnt   <= cnt + 1'b1;
            state <= NEXT;
          end else if (cnt == CNT_END) begin
            cnt      <= '0;
            stop_cnt <= ~stop_cnt;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        NEXT: begin
          cnt <= '0;
          if (quit || byte_idx_o == LAST_IDX) begin
            state      <= IDLE;
            busy_o     <= 1'b0;
            tx_o       <= 1'b1;
            byte_idx_o <= '0;
            done_o     <= ~quit;
            abort_o    <= quit;
          end else begin
            state      <= LOAD;
            tx_o       <= 1'b0;
            byte_idx_o <= byte_idx_o + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_uart_streamer.sv
// Bench for key_uart_streamer: three configurations driven from vector tables and random keys,
// each waveform compared cycle by cycle against a frame-level model of the UART stream.
module tb_key_uart_streamer;

  localparam int CPB  = 4;
  localparam int F_AB = 10 * CPB;
  localparam int N_AB = 6;
  localparam int F_C  = 12 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b1;
  logic        start_ab = 1'b0;
  logic        start_c = 1'b0;
  logic [31:0] key_ab = '0;
  logic [7:0]  key_c = '0;

  logic       busy_a, done_a, abort_a, tx_a;
  logic [2:0] idx_a;
  logic       busy_b, done_b, abort_b, tx_b;
  logic [2:0] idx_b;
  logic       busy_c, done_c, abort_c, tx_c;
  logic [1:0] idx_c;

  int vectors = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  key_uart_streamer #(.CLKS_PER_BIT(CPB), .NUM_BYTES(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .start_i(start_ab), .key_i(key_ab),
    .busy_o(busy_a), .done_o(done_a), .abort_o(abort_a), .byte_idx_o(idx_a), .tx_o(tx_a));

  key_uart_streamer #(.CLKS_PER_BIT(CPB), .NUM_BYTES(4), .MSB_FIRST(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .start_i(start_ab), .key_i(key_ab),
    .busy_o(busy_b), .done_o(done_b), .abort_o(abort_b), .byte_idx_o(idx_b), .tx_o(tx_b));

  key_uart_streamer #(.CLKS_PER_BIT(CPB), .NUM_BYTES(1), .HEADER_EN(0), .CHK_EN(0),
                      .PARITY_EN(1), .STOP_BITS(2)) dut_c (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .start_i(start_c), .key_i(key_c),
    .busy_o(busy_c), .done_o(done_c), .abort_o(abort_c), .byte_idx_o(idx_c), .tx_o(tx_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // expected line level at period p of a stream of 8N1 frames (no parity)
  function automatic logic uart_level(input logic [7:0] frames[N_AB], input int p);
    int f, bp;
    f  = p / F_AB;
    bp = (p % F_AB) / CPB;
    if (bp == 0) return 1'b0;
    if (bp <= 8) return frames[f][bp-1];
    return 1'b1;
  endfunction

  task automatic run_ab(input logic [31:0] k, input logic [7:0] chk_exp,
                        input int poke, input int abort_at, input string name);
    logic [7:0] fa[N_AB];
    logic [7:0] fb[N_AB];
    int nfr, ea, eb;
    fa[0] = 8'hA5;
    fb[0] = 8'hA5;
    for (int j = 0; j < 4; j++) begin
      fa[1+j] = k[j*8 +: 8];
      fb[1+j] = k[(3-j)*8 +: 8];
    end
    fa[5] = chk_exp;
    fb[5] = chk_exp;
    nfr = (abort_at >= 0) ? abort_at + 1 : N_AB;
    ea = 0;
    eb = 0;
    enable   = 1'b1;
    key_ab   = k;
    start_ab = 1'b1;
    tick();
    start_ab = 1'b0;
    for (int p = 0; p < nfr * F_AB; p++) begin
      if (tx_a !== uart_level(fa, p) || busy_a !== 1'b1 || idx_a !== 3'(p / F_AB)
          || done_a !== 1'b0 || abort_a !== 1'b0) ea++;
      if (tx_b !== uart_level(fb, p) || busy_b !== 1'b1 || idx_b !== 3'(p / F_AB)
          || done_b !== 1'b0 || abort_b !== 1'b0) eb++;
      if (p % F_AB == F_AB - 1) begin
        check($sformatf("%s_a_frame%0d_bad_cycles", name, p / F_AB), ea, 0);
        check($sformatf("%s_b_frame%0d_bad_cycles", name, p / F_AB), eb, 0);
        ea = 0;
        eb = 0;
      end
      if (p == poke) begin
        key_ab   = '1;
        start_ab = 1'b1;
      end
      if (p == poke + 1) start_ab = 1'b0;
      if (abort_at >= 0 && p == abort_at * F_AB + 10) enable = 1'b0;
      tick();
    end
    check({name, "_a_end_done_abort_busy_tx_idx"}, {done_a, abort_a, busy_a, tx_a, 1'b0, idx_a},
          {(abort_at < 0), (abort_at >= 0), 1'b0, 1'b1, 4'h0});
    check({name, "_b_end_done_abort_busy_tx_idx"}, {done_b, abort_b, busy_b, tx_b, 1'b0, idx_b},
          {(abort_at < 0), (abort_at >= 0), 1'b0, 1'b1, 4'h0});
    enable = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check({name, "_idle_after_busy_tx_done_abort"}, {busy_a, busy_b, tx_a, tx_b, done_a, abort_a},
          6'b001100);
  endtask

  task automatic run_c(input logic [7:0] k, input logic [11:0] pat, input string name);
    int e;
    e = 0;
    key_c   = k;
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    for (int p = 0; p < F_C; p++) begin
      if (tx_c !== pat[p / CPB] || busy_c !== 1'b1 || done_c !== 1'b0) e++;
      tick();
    end
    check({name, "_bad_cycles"}, e, 0);
    check({name, "_end_done_busy_tx_abort"}, {done_c, busy_c, tx_c, abort_c}, 4'b1010);
    tick();
    check({name, "_done_one_cycle"}, {done_c, busy_c}, 2'b00);
  endtask

  typedef struct {
    logic [31:0] key;
    logic [7:0]  chk;
    int          poke;
    int          abort_at;
    string       name;
  } ab_vec_t;

  typedef struct {
    logic [7:0]  key;
    logic [11:0] pat;
    string       name;
  } c_vec_t;

  initial begin
    ab_vec_t ab_tab[6];
    c_vec_t  c_tab[3];
    logic [31:0] rk;
    logic [7:0]  rchk;

    ab_tab[0] = '{32'h44332211, 8'h44, -1, -1, "basic"};
    ab_tab[1] = '{32'h00000000, 8'h00, -1, -1, "zeros"};
    ab_tab[2] = '{32'hFFFFFFFF, 8'h00, -1, -1, "ones"};
    ab_tab[3] = '{32'h80FF7F01, 8'h01, -1, -1, "mixed"};
    ab_tab[4] = '{32'h44332211, 8'h44, 100, -1, "snapshot"};
    ab_tab[5] = '{32'h01020408, 8'h0F, -1, 2, "abort"};

    // bit 0 is the start bit, then 8 data bits, even parity, two stop bits
    c_tab[0] = '{8'h07, 12'b111000001110, "par07"};
    c_tab[1] = '{8'hFF, 12'b110111111110, "parFF"};
    c_tab[2] = '{8'h01, 12'b111000000010, "par01"};

    rst = 1'b0;
    tick();
    tick();
    check("reset_a_tx_busy_done_abort", {tx_a, busy_a, done_a, abort_a}, 4'b1000);
    check("reset_a_idx", idx_a, 0);
    check("reset_c_tx_busy", {tx_c, busy_c}, 2'b10);
    rst = 1'b1;
    tick();

    enable   = 1'b0;
    start_ab = 1'b1;
    tick();
    start_ab = 1'b0;
    check("start_without_enable_busy_tx", {busy_a, busy_b, tx_a}, 3'b001);
    enable = 1'b1;
    tick();

    foreach (c_tab[i]) run_c(c_tab[i].key, c_tab[i].pat, c_tab[i].name);

    foreach (ab_tab[i])
      run_ab(ab_tab[i].key, ab_tab[i].chk, ab_tab[i].poke, ab_tab[i].abort_at, ab_tab[i].name);

    // reset during a data bit of frame 1
    key_ab   = 32'hDEADBEEF;
    start_ab = 1'b1;
    tick();
    start_ab = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    rst = 1'b0;
    tick();
    check("midreset_tx_busy", {tx_a, busy_a, tx_b, busy_b}, 4'b1010);
    rst = 1'b1;
    tick();
    run_ab(32'hDEADBEEF, 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF, -1, -1, "after_reset");

    for (int r = 0; r < 4; r++) begin
      rk   = $urandom;
      rchk = 8'h00;
      for (int j = 0; j < 4; j++) rchk ^= rk[j*8 +: 8];
      run_ab(rk, rchk, -1, -1, $sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
